// File: rtl/vga_pkg.sv
//------------------------------------------------------------------------------
// Module : vga_pkg
// Shared VGA timing types: line_t, measurement FSM states, counter default.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vga_pkg;

    localparam int MaxLineCounter = 4095;

    typedef struct packed {
        logic [11:0] visible_area;
        logic [11:0] front_porch;
        logic [11:0] sync_pulse;
        logic [11:0] back_porch;
    } line_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACT  = 3'd1,
        FRP  = 3'd2,
        SYN  = 3'd3,
        BCP  = 3'd4
    } meas_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_line_meas.sv
//------------------------------------------------------------------------------
// Module : vga_line_meas
// Measures active/front-porch/sync/back-porch lengths of one DE/sync axis and
// publishes them once stable. Optional VGA_LINE_MEAS_POL_EN: sync polarity
// auto-detection and pol_o output.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_line_meas
    import vga_pkg::*;
#(
    parameter int MAX_COUNTER = MaxLineCounter,
    parameter int LOCK_COUNT  = 2
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  inc_i,
    input  logic  de_i,
    input  logic  syn_i,
    output line_t line_o,
    output logic  valid_o,
    output logic  sol_o,
    output logic  err_o
`ifdef VGA_LINE_MEAS_POL_EN
    ,
    output logic  pol_o
`endif
);

    localparam int CW = $clog2(MAX_COUNTER + 1);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int LW = $bits(line_t) / 4;

    meas_state_e      r_state;
    logic [CW-1:0]    r_cnt;
    logic [LW-1:0]    r_act;
    logic [LW-1:0]    r_frp;
    logic [LW-1:0]    r_syn;
    line_t            r_cand;
    logic [MW-1:0]    r_match;
    logic             r_first;

    logic             w_syn;
    logic             w_idle_clash;
    logic             w_err;
    logic             w_adv;
    logic             w_cont;
    meas_state_e      w_next;
    line_t            w_cand;
    logic             w_same;
    logic [MW-1:0]    w_match_new;

    // With polarity detection the sync level seen on the first DE tick defines
    // "inactive", so a level change while DE is high shows up as de&sync.
`ifdef VGA_LINE_MEAS_POL_EN
    assign w_syn        = syn_i ^ ~pol_o;
    assign w_idle_clash = 1'b0;
`else
    assign w_syn        = syn_i;
    assign w_idle_clash = syn_i;
`endif

    assign w_cand      = {r_act, r_frp, r_syn, LW'(r_cnt)};
    assign w_same      = (w_cand == r_cand);
    assign w_match_new = !w_same                          ? MW'(1) :
                         (r_match == MW'(LOCK_COUNT))     ? r_match :
                                                            r_match + 1'b1;

    always_comb begin
        w_err  = 1'b0;
        w_adv  = 1'b0;
        w_cont = 1'b0;
        w_next = IDLE;
        case (r_state)
            IDLE: begin
                w_next = ACT;
                if (de_i) begin
                    if (w_idle_clash) w_err = 1'b1;
                    else              w_adv = 1'b1;
                end
            end
            ACT: begin
                w_next = FRP;
                if (w_syn)     w_err  = 1'b1;
                else if (de_i) w_cont = 1'b1;
                else           w_adv  = 1'b1;
            end
            FRP: begin
                w_next = SYN;
                if (de_i)       w_err  = 1'b1;
                else if (w_syn) w_adv  = 1'b1;
                else            w_cont = 1'b1;
            end
            SYN: begin
                w_next = BCP;
                if (de_i)       w_err  = 1'b1;
                else if (w_syn) w_cont = 1'b1;
                else            w_adv  = 1'b1;
            end
            BCP: begin
                w_next = ACT;
                if (w_syn)     w_err  = 1'b1;
                else if (de_i) w_adv  = 1'b1;
                else           w_cont = 1'b1;
            end
            default: w_err = 1'b1;
        endcase
        // Counter never wraps: reaching MAX_COUNTER aborts the measurement.
        if (w_cont && (r_cnt == CW'(MAX_COUNTER - 1))) begin
            w_cont = 1'b0;
            w_err  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_act   <= '0;
            r_frp   <= '0;
            r_syn   <= '0;
            r_cand  <= '0;
            r_match <= '0;
            r_first <= 1'b0;
            line_o  <= '0;
            valid_o <= 1'b0;
            sol_o   <= 1'b0;
            err_o   <= 1'b0;
`ifdef VGA_LINE_MEAS_POL_EN
            pol_o   <= 1'b1;
`endif
        end else begin
            sol_o <= 1'b0;
            err_o <= 1'b0;
            if (inc_i) begin
                if (w_err) begin
                    err_o   <= 1'b1;
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_match <= '0;
                    valid_o <= 1'b0;
                end else if (w_cont) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_adv) begin
                    r_state <= w_next;
                    r_cnt   <= CW'(1);
                    case (r_state)
                        IDLE: begin
                            r_first <= 1'b1;
`ifdef VGA_LINE_MEAS_POL_EN
                            pol_o   <= ~syn_i;
`endif
                        end
                        ACT: r_act <= LW'(r_cnt);
                        FRP: r_frp <= LW'(r_cnt);
                        SYN: r_syn <= LW'(r_cnt);
                        BCP: begin
                            sol_o   <= 1'b1;
                            r_first <= 1'b0;
                            // The line entered from IDLE may be partial; skip it.
                            if (!r_first) begin
                                r_cand  <= w_cand;
                                r_match <= w_match_new;
                                if (w_match_new == MW'(LOCK_COUNT)) begin
                                    line_o  <= w_cand;
                                    valid_o <= 1'b1;
                                end else if (!w_same) begin
                                    valid_o <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_line_meas.sv
//------------------------------------------------------------------------------
// Module : tb_vga_line_meas
// Directed self-checking bench for vga_line_meas.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_line_meas;
    import vga_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_i = 1'b1;
    logic  inc_i = 1'b0;
    logic  de_i  = 1'b0;
    logic  syn_i = 1'b0;
    line_t line_o;
    logic  valid_o;
    logic  sol_o;
    logic  err_o;
`ifdef VGA_LINE_MEAS_POL_EN
    logic  pol_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int sol_cnt  = 0;
    int err_cnt  = 0;
    int div      = 1;
    logic inv    = 1'b0;

    always #5 clk_i = ~clk_i;

    vga_line_meas #(
        .MAX_COUNTER (1024),
        .LOCK_COUNT  (2)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc_i),
        .de_i    (de_i),
        .syn_i   (syn_i),
        .line_o  (line_o),
        .valid_o (valid_o),
        .sol_o   (sol_o),
        .err_o   (err_o)
`ifdef VGA_LINE_MEAS_POL_EN
        ,
        .pol_o   (pol_o)
`endif
    );

    function automatic line_t mk(input int a, input int f, input int s, input int b);
        line_t l;
        l.visible_area = 12'(a);
        l.front_porch  = 12'(f);
        l.sync_pulse   = 12'(s);
        l.back_porch   = 12'(b);
        return l;
    endfunction

    // One sampled tick, stretched to div clocks with inc_i on the last one.
    task automatic send(input logic de, input logic syn);
        for (int k = 0; k < div; k++) begin
            @(negedge clk_i);
            de_i  = de;
            syn_i = syn ^ inv;
            inc_i = (k == div - 1);
            @(posedge clk_i);
            #1;
            if (sol_o) sol_cnt++;
            if (err_o) err_cnt++;
        end
    endtask

    task automatic head();
        send(1'b1, 1'b0);
    endtask

    task automatic tail(input int a_rest, input int f, input int s, input int b);
        for (int i = 0; i < a_rest; i++) send(1'b1, 1'b0);
        for (int i = 0; i < f; i++)      send(1'b0, 1'b0);
        for (int i = 0; i < s; i++)      send(1'b0, 1'b1);
        for (int i = 0; i < b; i++)      send(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        inc_i = 1'b0;
        de_i  = 1'b0;
        syn_i = inv;
        @(negedge clk_i);
        rst_i   = 1'b0;
        sol_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk_i);
        #1;
        n_checks++;
        if (line_o !== '0) begin n_fail++; $display("FAIL reset_line: got %h want 0", line_o); end
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++;
        if (sol_o !== 1'b0) begin n_fail++; $display("FAIL reset_sol: got %b want 0", sol_o); end
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
`ifdef VGA_LINE_MEAS_POL_EN
        n_checks++;
        if (pol_o !== 1'b1) begin n_fail++; $display("FAIL reset_pol: got %b want 1", pol_o); end
`endif
    endtask

    // Shared by the lock and the slow-inc scenarios: three full lines, then a rise.
    task automatic lock_sequence(input string tag);
        line_t exp;
        exp = mk(640, 16, 96, 48);
        for (int i = 0; i < 3; i++) begin
            head();
            tail(639, 16, 96, 48);
        end
        head();
        n_checks++;
        if (valid_o !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", tag, valid_o); end
        n_checks++;
        if (line_o !== exp) begin
            n_fail++;
            $display("FAIL %s_line: got {%0d,%0d,%0d,%0d} want {640,16,96,48}", tag,
                     line_o.visible_area, line_o.front_porch, line_o.sync_pulse, line_o.back_porch);
        end
        n_checks++;
        if (sol_cnt !== 3) begin n_fail++; $display("FAIL %s_sol_count: got %0d want 3", tag, sol_cnt); end
        n_checks++;
        if (err_cnt !== 0) begin n_fail++; $display("FAIL %s_err_count: got %0d want 0", tag, err_cnt); end
    endtask

    task automatic test_lock();
        lock_sequence("lock");
        tail(639, 16, 96, 48);
        head();
        n_checks++;
        if (sol_o !== 1'b1 || sol_cnt !== 4) begin
            n_fail++;
            $display("FAIL lock_sol_period: sol=%b count=%0d want 1/4", sol_o, sol_cnt);
        end
    endtask

    task automatic test_porch_change();
        tail(639, 17, 96, 48);
        head();
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL fp_change_valid: got %b want 0", valid_o); end
        n_checks++;
        if (line_o.front_porch !== 12'd16) begin
            n_fail++; $display("FAIL fp_change_hold: got %0d want 16", line_o.front_porch);
        end
        tail(639, 17, 96, 48);
        head();
        n_checks++;
        if (valid_o !== 1'b1 || line_o.front_porch !== 12'd17) begin
            n_fail++;
            $display("FAIL fp_relock: valid=%b fp=%0d want 1/17", valid_o, line_o.front_porch);
        end
    endtask

    task automatic test_sync_glitch();
        err_cnt = 0;
        for (int i = 0; i < 99; i++) send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        n_checks++;
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL glitch_err: got %b want 1", err_o); end
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", valid_o); end
        n_checks++;
        if (line_o.front_porch !== 12'd17) begin
            n_fail++; $display("FAIL glitch_line_hold: got %0d want 17", line_o.front_porch);
        end
        send(1'b1, 1'b0);
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL glitch_err_pulse: got %b want 0", err_o); end
        tail(538, 17, 96, 48);
        head();
        tail(639, 17, 96, 48);
        head();
        n_checks++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL glitch_early_valid: got %b want 0", valid_o); end
        tail(639, 17, 96, 48);
        head();
        n_checks++;
        if (valid_o !== 1'b1 || err_cnt !== 1) begin
            n_fail++;
            $display("FAIL glitch_relock: valid=%b errs=%0d want 1/1", valid_o, err_cnt);
        end
    endtask

    task automatic test_overflow();
        int first_err;
        do_reset();
        first_err = 0;
        for (int i = 1; i <= 1024; i++) begin
            send(1'b1, 1'b0);
            if (err_o && first_err == 0) first_err = i;
        end
        n_checks++;
        if (first_err !== 1024) begin n_fail++; $display("FAIL ovf_tick: got %0d want 1024", first_err); end
        // Back in IDLE a lone sync tick is ignored; in ACT it would be an error.
        send(1'b0, 1'b1);
        n_checks++;
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_idle: got err=%b want 0", err_o); end
        for (int i = 0; i < 75; i++) send(1'b1, 1'b0);
        n_checks++;
        if (err_cnt !== 1 || valid_o !== 1'b0 || sol_cnt !== 0) begin
            n_fail++;
            $display("FAIL ovf_nowrap: errs=%0d valid=%b sols=%0d want 1/0/0", err_cnt, valid_o, sol_cnt);
        end
    endtask

    task automatic test_slow_inc();
        do_reset();
        div = 3;
        lock_sequence("slow");
        tail(639, 16, 40, 0);
        #2;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (line_o !== '0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: line=%h valid=%b want 0/0", line_o, valid_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        div   = 1;
    endtask

`ifdef VGA_LINE_MEAS_POL_EN
    task automatic test_polarity();
        inv = 1'b1;
        do_reset();
        lock_sequence("pol");
        n_checks++;
        if (pol_o !== 1'b0) begin n_fail++; $display("FAIL pol_level: got %b want 0", pol_o); end
        inv = 1'b0;
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lock();
        test_porch_change();
        test_sync_glitch();
        test_overflow();
        test_slow_inc();
`ifdef VGA_LINE_MEAS_POL_EN
        test_polarity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
